// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer
//   Tile-level control for the MAC array and its kernel / feature / output
//   register banks. It drives only the control and enable pins; no data
//   passes through this block.
//
//   Tile flow: IDLE -> LOAD_K -> LOAD_F -> SWAP -> COMPUTE -> FLUSH ->
//              WRITEBACK -> DRAIN -> IDLE
//
// Ports
//   clk, arst_n_in            clock, asynchronous active-low reset
//   start                     begin a tile (sampled in IDLE only)
//   kernel_words              kernel rows to load (0 skips LOAD_K), latched
//   tap_count                 taps to accumulate (0 -> 1, clamped), latched
//   a_valid / a_ready         paired a_input/b_input stream handshake
//   kernel_we                 per-bank kernel SRAM write enables
//   kernel_write_addr         kernel SRAM write row
//   kernel_re/kernel_read_addr kernel SRAM read (data valid one cycle later)
//   next_feature_we           Next_Feature register write enables
//   feature_we                Feature <- Next_Feature
//   mux18_select              feature mux select (aligned with mac_valid)
//   mac_valid, mac_accumulate_internal  MAC lane controls
//   output_we                 output register capture
//   out_sel                   output register routed to the port
//   output_valid/output_ready output drain handshake
//   running                   tile in progress
//   done                      one-cycle tile-complete pulse
module mac_array_sequencer #(
    parameter int NB_MACS         = 16,   // must be even
    parameter int NB_FEATURE_REGS = 18,   // must be even and <= 32
    parameter int KERNEL_HEIGHT   = 128
) (
    input  logic                               clk,
    input  logic                               arst_n_in,
    input  logic                               start,
    input  logic [$clog2(KERNEL_HEIGHT+1)-1:0] kernel_words,
    input  logic [4:0]                         tap_count,
    input  logic                               a_valid,
    output logic                               a_ready,
    output logic [NB_MACS-1:0]                 kernel_we,
    output logic [$clog2(KERNEL_HEIGHT)-1:0]   kernel_write_addr,
    output logic [$clog2(KERNEL_HEIGHT)-1:0]   kernel_read_addr,
    output logic                               kernel_re,
    output logic [NB_FEATURE_REGS-1:0]         next_feature_we,
    output logic                               feature_we,
    output logic [4:0]                         mux18_select,
    output logic                               mac_valid,
    output logic                               mac_accumulate_internal,
    output logic                               output_we,
    output logic [$clog2(NB_MACS)-1:0]         out_sel,
    output logic                               output_valid,
    input  logic                               output_ready,
    output logic                               running,
    output logic                               done
);

    localparam int KW_W      = $clog2(KERNEL_HEIGHT + 1);
    localparam int KA_W      = $clog2(KERNEL_HEIGHT);
    localparam int OS_W      = $clog2(NB_MACS);
    localparam int PAIRS_K   = NB_MACS / 2;
    localparam int PAIRS_F   = NB_FEATURE_REGS / 2;
    localparam int PAIRS_MAX = (PAIRS_K > PAIRS_F) ? PAIRS_K : PAIRS_F;
    localparam int PC_W      = (PAIRS_MAX > 1) ? $clog2(PAIRS_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_LOAD_F,
        S_SWAP,
        S_COMPUTE,
        S_FLUSH,
        S_WRITEBACK,
        S_DRAIN
    } state_t;

    // MAC-side controls, delayed one cycle behind the kernel read issue so
    // they line up with the SRAM read data.
    typedef struct packed {
        logic       valid;
        logic       acc;
        logic [4:0] sel;
    } mac_ctrl_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pair_q, pair_d;      // shared by LOAD_K and LOAD_F
    logic [KA_W-1:0]   row_q, row_d;
    logic [4:0]        tap_q, tap_d;
    logic [OS_W-1:0]   out_sel_q, out_sel_d;
    logic [KW_W-1:0]   kwords_q, kwords_d;
    logic [4:0]        taps_q, taps_d;      // clamped tap count, 1..NB_FEATURE_REGS
    logic              done_q, done_d;
    mac_ctrl_t         mac_q, mac_d;

    logic              k_hs;                // kernel-row handshake this cycle
    logic              f_hs;                // feature-pair handshake this cycle

    function automatic logic [4:0] clamp_taps(input logic [4:0] tc);
        if (tc == 5'd0)
            return 5'd1;
        if (int'(tc) > NB_FEATURE_REGS)
            return 5'(NB_FEATURE_REGS);
        return tc;
    endfunction

    // ------------------------------------------------------------------
    // Next-state and combinational controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pair_d       = pair_q;
        row_d        = row_q;
        tap_d        = tap_q;
        out_sel_d    = out_sel_q;
        kwords_d     = kwords_q;
        taps_d       = taps_q;
        done_d       = 1'b0;
        a_ready      = 1'b0;
        k_hs         = 1'b0;
        f_hs         = 1'b0;
        kernel_re    = 1'b0;
        feature_we   = 1'b0;
        output_we    = 1'b0;
        output_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kwords_d  = kernel_words;
                    taps_d    = clamp_taps(tap_count);
                    pair_d    = '0;
                    row_d     = '0;
                    tap_d     = '0;
                    out_sel_d = '0;
                    state_d   = (kernel_words != '0) ? S_LOAD_K : S_LOAD_F;
                end
            end

            S_LOAD_K: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    k_hs = 1'b1;
                    if (pair_q == PC_W'(PAIRS_K - 1)) begin
                        pair_d = '0;
                        if (KW_W'(row_q) == kwords_q - KW_W'(1)) begin
                            row_d   = '0;
                            state_d = S_LOAD_F;
                        end else begin
                            row_d = row_q + KA_W'(1);
                        end
                    end else begin
                        pair_d = pair_q + PC_W'(1);
                    end
                end
            end

            S_LOAD_F: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    f_hs = 1'b1;
                    if (pair_q == PC_W'(PAIRS_F - 1)) begin
                        pair_d  = '0;
                        state_d = S_SWAP;
                    end else begin
                        pair_d = pair_q + PC_W'(1);
                    end
                end
            end

            S_SWAP: begin
                feature_we = 1'b1;
                state_d    = S_COMPUTE;
            end

            S_COMPUTE: begin
                kernel_re = 1'b1;
                if (tap_q == taps_q - 5'd1) begin
                    tap_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    tap_d = tap_q + 5'd1;
                end
            end

            // Carries the last delayed mac_valid before results are captured.
            S_FLUSH: state_d = S_WRITEBACK;

            S_WRITEBACK: begin
                output_we = 1'b1;
                state_d   = S_DRAIN;
            end

            S_DRAIN: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    if (out_sel_q == OS_W'(NB_MACS - 1)) begin
                        out_sel_d = '0;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        out_sel_d = out_sel_q + OS_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // MAC controls for the tap being issued now; registered below.
    always_comb begin
        mac_d = '0;
        if (kernel_re) begin
            mac_d.valid = 1'b1;
            mac_d.acc   = (tap_q != 5'd0);
            mac_d.sel   = tap_q;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q   <= S_IDLE;
            pair_q    <= '0;
            row_q     <= '0;
            tap_q     <= '0;
            out_sel_q <= '0;
            kwords_q  <= '0;
            taps_q    <= '0;
            done_q    <= 1'b0;
            mac_q     <= '0;
        end else begin
            state_q   <= state_d;
            pair_q    <= pair_d;
            row_q     <= row_d;
            tap_q     <= tap_d;
            out_sel_q <= out_sel_d;
            kwords_q  <= kwords_d;
            taps_q    <= taps_d;
            done_q    <= done_d;
            mac_q     <= mac_d;
        end
    end

    // ------------------------------------------------------------------
    // Write-enable decode: each handshake writes one even/odd pair.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < PAIRS_K; gi++) begin : g_kernel_we
        assign kernel_we[2*gi +: 2] = {2{k_hs && (pair_q == PC_W'(gi))}};
    end

    for (genvar gi = 0; gi < PAIRS_F; gi++) begin : g_feature_we
        assign next_feature_we[2*gi +: 2] = {2{f_hs && (pair_q == PC_W'(gi))}};
    end

    assign kernel_write_addr       = (state_q == S_LOAD_K) ? row_q : '0;
    assign kernel_read_addr        = kernel_re ? KA_W'(tap_q) : '0;
    assign mac_valid               = mac_q.valid;
    assign mac_accumulate_internal = mac_q.acc;
    assign mux18_select            = mac_q.sel;
    assign out_sel                 = out_sel_q;
    assign running                 = (state_q != S_IDLE);
    assign done                    = done_q;

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Bench for mac_array_sequencer: a table of tile configurations is run back
// to back (each start lands in the previous tile's done cycle). Expected
// enables, addresses and cycle positions are queued when a tile is started
// and popped by a negedge monitor as the DUT produces them. Hand-written
// sequences cover reset state and reset mid-COMPUTE.
module tb_mac_array_sequencer;

    localparam int NB_MACS = 16;
    localparam int NB_FR   = 18;
    localparam int KH      = 128;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        start;
    logic [7:0]  kernel_words;
    logic [4:0]  tap_count;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] kernel_we;
    logic [6:0]  kernel_write_addr;
    logic [6:0]  kernel_read_addr;
    logic        kernel_re;
    logic [17:0] next_feature_we;
    logic        feature_we;
    logic [4:0]  mux18_select;
    logic        mac_valid;
    logic        mac_accumulate_internal;
    logic        output_we;
    logic [3:0]  out_sel;
    logic        output_valid;
    logic        output_ready;
    logic        running;
    logic        done;

    mac_array_sequencer #(
        .NB_MACS(NB_MACS), .NB_FEATURE_REGS(NB_FR), .KERNEL_HEIGHT(KH)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start),
        .kernel_words(kernel_words), .tap_count(tap_count),
        .a_valid(a_valid), .a_ready(a_ready),
        .kernel_we(kernel_we), .kernel_write_addr(kernel_write_addr),
        .kernel_read_addr(kernel_read_addr), .kernel_re(kernel_re),
        .next_feature_we(next_feature_we), .feature_we(feature_we),
        .mux18_select(mux18_select), .mac_valid(mac_valid),
        .mac_accumulate_internal(mac_accumulate_internal),
        .output_we(output_we), .out_sel(out_sel),
        .output_valid(output_valid), .output_ready(output_ready),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int base  = 0;
    int mrel;
    bit mon_en   = 1'b0;
    bit stalling = 1'b0;

    logic [31:0] kq[$];   // {kernel_we, kernel_write_addr}
    logic [31:0] fq[$];   // next_feature_we
    logic [31:0] rq[$];   // {read addr, cycle}
    logic [31:0] mq[$];   // {select, accumulate, cycle}
    logic [31:0] oq[$];   // out_sel per drain handshake
    int          fwq[$];  // feature_we cycle
    int          owq[$];  // output_we cycle

    typedef struct {
        int kw;
        int tc;
        int et;     // effective taps
        bit tog;    // a_valid toggles 1,0,1,0...
        int stl;    // output_ready stall cycles at out_sel = 7
        int edone;  // done cycle relative to the start-sample edge
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc - base);
        end
    endtask

    task automatic unexp(input string nm, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", nm, act, cyc - base);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops expectations as the DUT produces events.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            mrel = cyc - base;
            if (kernel_we != '0) begin
                if (kq.size() == 0) unexp("kernel_we", {kernel_we, kernel_write_addr});
                else chk("kernel_we_addr", {kernel_we, kernel_write_addr}, kq.pop_front());
            end
            if (next_feature_we != '0) begin
                if (fq.size() == 0) unexp("next_feature_we", next_feature_we);
                else chk("next_feature_we", next_feature_we, fq.pop_front());
            end
            if (!a_valid)
                chk("we_while_a_stalled", {kernel_we, next_feature_we}, 0);
            if (feature_we) begin
                if (fwq.size() == 0) unexp("feature_we", mrel);
                else chk("feature_we_cycle", mrel, fwq.pop_front());
            end
            if (kernel_re) begin
                if (rq.size() == 0) unexp("kernel_re", kernel_read_addr);
                else chk("kernel_read", (32'(kernel_read_addr) << 16) | 32'(mrel), rq.pop_front());
            end
            if (mac_valid) begin
                if (mq.size() == 0) unexp("mac_valid", mux18_select);
                else chk("mac_ctrl", (32'(mux18_select) << 24) | (32'(mac_accumulate_internal) << 20) | 32'(mrel),
                         mq.pop_front());
            end
            if (output_we) begin
                if (owq.size() == 0) unexp("output_we", mrel);
                else chk("output_we_cycle", mrel, owq.pop_front());
            end
            if (output_valid && output_ready) begin
                if (oq.size() == 0) unexp("drain", out_sel);
                else chk("out_sel", out_sel, oq.pop_front());
            end
            if (stalling)
                chk("drain_hold", {output_valid, out_sel}, {1'b1, 4'd7});
        end
    end

    task automatic clear_queues();
        kq.delete(); fq.delete(); rq.delete(); mq.delete(); oq.delete();
        fwq.delete(); owq.delete();
    endtask

    // Starts a tile in the current cycle and drives it until done.
    task automatic run_tile(input int kw, input int tc, input int et, input bit tog,
                            input int stl, input int edone);
        int f, sl, rel;
        bit fin;
        f = 8 * kw + (tog ? 8 : 0);
        for (int r = 0; r < kw; r++)
            for (int p = 0; p < NB_MACS / 2; p++)
                kq.push_back(32'({16'(32'd3 << (2 * p)), 7'(r)}));
        for (int q = 0; q < NB_FR / 2; q++)
            fq.push_back(32'(18'(32'd3 << (2 * q))));
        fwq.push_back(f + 10);
        for (int t = 0; t < et; t++) begin
            rq.push_back((32'(t) << 16) | 32'(f + 11 + t));
            mq.push_back((32'(t) << 24) | (32'(t != 0) << 20) | 32'(f + 12 + t));
        end
        owq.push_back(f + 12 + et);
        for (int i = 0; i < NB_MACS; i++) oq.push_back(32'(i));

        kernel_words = 8'(kw);
        tap_count    = 5'(tc);
        start        = 1'b1;
        a_valid      = 1'b1;
        output_ready = 1'b1;
        base         = cyc;
        sl           = stl;
        fin          = 1'b0;
        rel          = 0;
        for (int n = 0; n < 600 && !fin; n++) begin
            @(posedge clk); #1;
            rel = cyc - base;
            if (done) begin
                chk("done_cycle", rel, edone);
                fin = 1'b1;
            end else begin
                if (rel == 1) chk("running_after_start", running, 1);
                a_valid = tog ? rel[0] : 1'b1;
                if (sl > 0 && (stalling || (output_valid && out_sel == 4'd7))) begin
                    stalling     = 1'b1;
                    output_ready = 1'b0;
                    start        = sl[0];   // ignored pulses during DRAIN
                    sl--;
                end else begin
                    stalling     = 1'b0;
                    output_ready = 1'b1;
                    start        = 1'b0;
                end
            end
        end
        if (!fin) unexp("done_timeout", rel);
        stalling = 1'b0;
        chk("queues_empty", kq.size() + fq.size() + rq.size() + mq.size() + oq.size()
            + fwq.size() + owq.size(), 0);
        clear_queues();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_a"}, {a_ready, kernel_we, kernel_write_addr, kernel_read_addr, kernel_re,
                         next_feature_we}, 0);
        chk({nm, "_b"}, {feature_we, mux18_select, mac_valid, mac_accumulate_internal,
                         output_we, out_sel, output_valid, running, done}, 0);
    endtask

    initial begin
        vecs[0] = '{0, 3, 3, 1'b0, 0, 32};
        vecs[1] = '{2, 4, 4, 1'b0, 0, 49};
        vecs[2] = '{0, 0, 1, 1'b0, 0, 30};
        vecs[3] = '{0, 25, 18, 1'b0, 0, 47};
        vecs[4] = '{0, 5, 5, 1'b1, 0, 42};
        vecs[5] = '{1, 2, 2, 1'b0, 5, 44};
        vecs[6] = '{0, 18, 18, 1'b0, 0, 47};

        arst_n_in    = 1'b0;
        start        = 1'b0;
        kernel_words = '0;
        tap_count    = '0;
        a_valid      = 1'b1;
        output_ready = 1'b1;

        #12;
        chk_all_zero("reset_state");
        #10 arst_n_in = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("idle_after_reset");

        mon_en = 1'b1;
        for (int i = 0; i < 7; i++)
            run_tile(vecs[i].kw, vecs[i].tc, vecs[i].et, vecs[i].tog, vecs[i].stl, vecs[i].edone);

        // Reset in the middle of COMPUTE (started in the previous done cycle).
        mon_en       = 1'b0;
        kernel_words = '0;
        tap_count    = 5'd5;
        start        = 1'b1;
        base         = cyc;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc - base == 12) break;
        end
        chk("compute_before_reset", {running, kernel_re, mac_valid}, 3'b111);
        #2 arst_n_in = 1'b0;
        #1;
        chk_all_zero("reset_mid_compute");
        @(negedge clk);
        @(negedge clk);
        arst_n_in = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("idle_after_mid_reset");

        mon_en = 1'b1;
        run_tile(0, 3, 3, 1'b0, 0, 32);
        start = 1'b0;
        @(posedge clk); #1;
        chk("final_idle", {running, done}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_array_sequencer.md
# mac_array_sequencer

Tile-level sequencer for the 16-lane MAC array and its feature/kernel/output register banks. Per tile it loads kernel SRAM rows and 18 feature words from the paired `a_input`/`b_input` stream, swaps the feature bank, sweeps the 18:1 feature mux with aligned MAC valid and accumulate controls, captures results into the output registers, and drains them one word per handshake. It drives only the control and enable pins of that datapath and passes no data itself.

## Interface
- `NB_MACS`, 16: MAC lanes, kernel banks and output registers; must be even.
- `NB_FEATURE_REGS`, 18: feature registers; must be even and ≤ 32.
- `KERNEL_HEIGHT`, 128: rows per kernel SRAM bank.
- `clk` in 1: clock.
- `arst_n_in` in 1: reset, asynchronous, active-low.
- `start` in 1: starts a tile; sampled only in IDLE.
- `kernel_words` in $clog2(KERNEL_HEIGHT+1): kernel rows to load this tile; 0 skips kernel load. Latched at start.
- `tap_count` in 5: number of taps to accumulate. Latched at start; 0 is treated as 1, values >NB_FEATURE_REGS as NB_FEATURE_REGS.
- `a_valid` in 1 / `a_ready` out 1: input-pair handshake.
- `kernel_we` out NB_MACS: bank write enables.
- `kernel_write_addr`, `kernel_read_addr` out $clog2(KERNEL_HEIGHT): SRAM row addresses.
- `kernel_re` out 1: SRAM read enable; data is valid 1 cycle later.
- `next_feature_we` out NB_FEATURE_REGS: Next_Feature write enables.
- `feature_we` out 1: Feature ← Next_Feature.
- `mux18_select` out 5: feature mux select.
- `mac_valid` out 1, `mac_accumulate_internal` out 1: MAC controls.
- `output_we` out 1: output register capture.
- `out_sel` out $clog2(NB_MACS): output register driven to the port.
- `output_valid` out 1 / `output_ready` in 1: output drain handshake.
- `running` out 1: state ≠ IDLE.
- `done` out 1: one-cycle tile-complete pulse.

## Operation
- States: IDLE → LOAD_K → LOAD_F → SWAP → COMPUTE → FLUSH → WRITEBACK → DRAIN → IDLE.
- IDLE: `start` goes to LOAD_K if `kernel_words` ≠ 0, otherwise to LOAD_F.
- LOAD_K:
  - `a_ready` = 1. A handshake is `a_valid & a_ready`.
  - Pair counter p runs 0..NB_MACS/2−1 (inner loop); row counter r runs 0..kernel_words−1 (outer loop).
  - On a handshake, `kernel_we` bits 2p and 2p+1 are set (a_input → even bank, b_input → odd bank) and `kernel_write_addr` = r.
  - Leaves for LOAD_F on the last handshake (p = max, r = kernel_words−1).
- LOAD_F:
  - `a_ready` = 1. Pair counter q runs 0..NB_FEATURE_REGS/2−1.
  - On a handshake, `next_feature_we` bits 2q and 2q+1 are set.
  - After NB_FEATURE_REGS/2 handshakes, goes to SWAP.
- SWAP: `feature_we` = 1 for one cycle, then COMPUTE.
- COMPUTE: tap t runs 0..T−1 (T = clamped tap_count), one per cycle. Drives `kernel_re` = 1 and `kernel_read_addr` = t. After t = T−1, goes to FLUSH.
- Delayed MAC controls, registered 1 cycle after each issue:
  - `mac_valid` = 1, `mux18_select` = t.
  - `mac_accumulate_internal` = 0 for t = 0, 1 otherwise.
- FLUSH: one cycle; carries the last delayed `mac_valid`.
- WRITEBACK: `output_we` = 1 for one cycle.
- DRAIN:
  - `output_valid` = 1; `out_sel` starts at 0.
  - Each `output_valid & output_ready` increments `out_sel`.
  - After the handshake at NB_MACS−1, returns to IDLE with `done` = 1 for that next cycle.
- `a_ready` = 0 outside LOAD_K/LOAD_F. `a_valid` is ignored in other states.
- All enables are 0 whenever their condition is not met.

## Timing
- Reset values: state IDLE, all counters 0, and every output 0 (`a_ready`, all write enables, `kernel_re`, addresses, `mux18_select`, `mac_valid`, `mac_accumulate_internal`, `output_we`, `out_sel`, `output_valid`, `running`, `done`).
- Reset mid-tile returns to IDLE immediately, with no further enables.
- Enables are combinational from state, counters and `a_valid`, so the SRAM/register write happens at the same edge as the handshake.
- `start` high while not in IDLE is ignored. `start` in the `done` cycle is accepted, since the state is IDLE then.
- A stalled `a_valid` holds all counters; `kernel_we` and `next_feature_we` stay 0 during the stall.
- A stalled `output_ready` holds `out_sel` and `output_valid`.
- With `kernel_words` = 0, a_valid = 1 and output_ready = 1, counting from the start-sample edge as cycle 0:
  - LOAD_F cycles 1..9, SWAP 10.
  - COMPUTE cycles 11..10+T; `mac_valid` cycles 12..11+T (FLUSH = 11+T).
  - WRITEBACK 12+T, DRAIN 13+T..28+T, `done` at 29+T.

## Test plan
- Reset asserted mid-COMPUTE → all outputs 0 in the same cycle; state IDLE; a new `start` runs a clean tile.
- kernel_words = 0, tap_count = 3, a_valid = 1, output_ready = 1 → `feature_we` at cycle 10; `mac_valid` at 12, 13, 14; `mac_accumulate_internal` = 0, 1, 1; `mux18_select` = 0, 1, 2; `output_we` at 15; `done` at 32.
- kernel_words = 2 → 16 handshakes; `kernel_we` = 0x0003, 0x000C, …, 0xC000 at addr 0, then the same sequence at addr 1; then LOAD_F.
- a_valid toggled 1,0,1,0 in LOAD_F → `next_feature_we` = 0x00003, 0, 0x0000C, 0; 9 handshakes total.
- tap_count = 0 → 1 tap; tap_count = 25 → 18 taps, with `mux18_select` ending at 17.
- output_ready low for 5 cycles at out_sel = 7 → `out_sel` holds at 7, `output_valid` stays 1; `start` pulses during DRAIN are ignored.
